axis_header_slicer: RTL and testbench

Ingress stage directly upstream of `packet_parser`. Accepts a raw AXI-Stream packet, captures the first `HDR_BEATS` beats of each packet into a single wide header slice for the parser, and forwards every beat unchanged through a one-deep registered AXI-Stream output. The block backpressures the source whenever a new header would overwrite a slice the parser has not yet taken.

---
 rtl/pp_package.sv | 18 +
 rtl/axis_out_reg.sv | 40 ++++
 rtl/axis_header_slicer.sv | 169 ++++++++++++++++
 tb/tb_axis_header_slicer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_package.sv
// Shared constants and types for the packet_parser ingress path.
package pp_package;

    localparam int DATA_WIDTH         = 64;
    localparam int HDR_BEATS          = 4;
    localparam int HEADER_SLICE_WIDTH = DATA_WIDTH * HDR_BEATS;

    typedef enum logic {
        S_HDR,
        S_BODY
    } slicer_state_t;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI-Stream output stage.
// The stage can take a new beat whenever it is empty or its current beat is
// being consumed in this cycle; that condition is exported as load_en.
module axis_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_keep,
    input  logic                    in_last,
    output logic                    load_en,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    assign load_en = !m_axis_tvalid || m_axis_tready;

    // Output register: refill or drain whenever the stage is free to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_en) begin
            m_axis_tvalid <= in_valid;
            if (in_valid) begin
                m_axis_tdata <= in_data;
                m_axis_tkeep <= in_keep;
                m_axis_tlast <= in_last;
            end
        end
    end

endmodule

// File: rtl/axis_header_slicer.sv
// Ingress stage for packet_parser: captures the first HDR_BEATS beats of each
// packet into one wide header slice and forwards every beat through a
// registered AXI-Stream output. Stalls a new packet at beat 0 while the
// previous slice has not been taken by the parser.
// Optional build macro HDR_SLICER_STATS_EN adds saturating pkt_count and
// short_count outputs.
module axis_header_slicer #(
    parameter int DATA_WIDTH = pp_package::DATA_WIDTH,
    parameter int HDR_BEATS  = pp_package::HDR_BEATS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH*HDR_BEATS-1:0] header_slice,
    output logic                            hdr_valid,
    output logic                            hdr_short,
`ifdef HDR_SLICER_STATS_EN
    output logic [31:0]                     pkt_count,
    output logic [15:0]                     short_count,
`endif
    input  logic                            hdr_ready
);

    import pp_package::*;

    localparam int SLICE_W = DATA_WIDTH * HDR_BEATS;
    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int CNT_W   = cnt_width(HDR_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HDR_BEATS - 1);

    slicer_state_t        state, state_n;
    logic [CNT_W-1:0]     beat_cnt, cnt_n;
    logic [SLICE_W-1:0]   slice_n;
    logic                 hdr_valid_n;
    logic                 hdr_short_n;
    logic [DATA_WIDTH-1:0] masked;
    logic                 load_en;
    logic                 beat_acc;

    assign s_axis_tready = load_en && !(state == S_HDR && hdr_valid);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (beat_acc),
        .in_data      (s_axis_tdata),
        .in_keep      (s_axis_tkeep),
        .in_last      (s_axis_tlast),
        .load_en      (load_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    // Zero the bytes of the incoming word whose tkeep bit is clear.
    always_comb begin
        masked = s_axis_tdata;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            if (!s_axis_tkeep[i]) begin
                masked[8*i +: 8] = '0;
            end
        end
    end

    // Next-state logic for the header FSM, beat counter and slice.
    // The slice is cleared on beat 0, so a short packet's uncaptured words
    // are already zero when hdr_valid rises.
    always_comb begin
        state_n     = state;
        cnt_n       = beat_cnt;
        slice_n     = header_slice;
        hdr_valid_n = hdr_valid;
        hdr_short_n = hdr_short;

        if (hdr_valid && hdr_ready) begin
            hdr_valid_n = 1'b0;
        end

        case (state)
            S_HDR: begin
                if (beat_acc) begin
                    if (beat_cnt == '0) begin
                        slice_n = '0;
                    end
                    for (int unsigned b = 0; b < HDR_BEATS; b++) begin
                        if (beat_cnt == CNT_W'(b)) begin
                            slice_n[SLICE_W-1-b*DATA_WIDTH -: DATA_WIDTH] = masked;
                        end
                    end
                    if (beat_cnt == LAST_CNT) begin
                        hdr_valid_n = 1'b1;
                        hdr_short_n = 1'b0;
                        cnt_n       = '0;
                        state_n     = s_axis_tlast ? S_HDR : S_BODY;
                    end else if (s_axis_tlast) begin
                        hdr_valid_n = 1'b1;
                        hdr_short_n = 1'b1;
                        cnt_n       = '0;
                    end else begin
                        cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (beat_acc && s_axis_tlast) begin
                    state_n = S_HDR;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_HDR;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and header output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HDR;
            beat_cnt     <= '0;
            header_slice <= '0;
            hdr_valid    <= 1'b0;
            hdr_short    <= 1'b0;
        end else begin
            state        <= state_n;
            beat_cnt     <= cnt_n;
            header_slice <= slice_n;
            hdr_valid    <= hdr_valid_n;
            hdr_short    <= hdr_short_n;
        end
    end

`ifdef HDR_SLICER_STATS_EN
    logic short_cap;

    assign short_cap = (state == S_HDR) && beat_acc && s_axis_tlast && (beat_cnt != LAST_CNT);

    // Saturating packet and short-header counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count   <= '0;
            short_count <= '0;
        end else begin
            if (beat_acc && s_axis_tlast && (pkt_count != '1)) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (short_cap && (short_count != '1)) begin
                short_count <= short_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_header_slicer.sv
// Self-checking bench for axis_header_slicer (DATA_WIDTH=64, HDR_BEATS=4).
// Scoreboard queues hold the expected m_axis beats and header slices; they are
// filled by the drivers and drained by negedge monitors.
module tb_axis_header_slicer;

    localparam int DW = 64;
    localparam int HB = 4;
    localparam int SW = DW * HB;

    typedef struct {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        logic            l;
        int              c;
    } beat_t;

    typedef struct {
        logic [SW-1:0] s;
        logic          sh;
    } hdr_t;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [DW/8-1:0] s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [SW-1:0]   header_slice;
    logic            hdr_valid;
    logic            hdr_short;
    logic            hdr_ready;
`ifdef HDR_SLICER_STATS_EN
    logic [31:0]     pkt_count;
    logic [15:0]     short_count;
`endif

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    last_hdr_cyc = 0;
    logic  check_lat = 1'b0;
    logic  chk_ready = 1'b0;
    beat_t sb[$];
    hdr_t  hq[$];

    axis_header_slicer #(
        .DATA_WIDTH(DW),
        .HDR_BEATS (HB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .header_slice (header_slice),
        .hdr_valid    (hdr_valid),
        .hdr_short    (hdr_short),
`ifdef HDR_SLICER_STATS_EN
        .pkt_count    (pkt_count),
        .short_count  (short_count),
`endif
        .hdr_ready    (hdr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat k of a packet: byte value base + (k+1)*0x11 replicated across the word.
    function automatic logic [DW-1:0] bdata(input int base, input int k);
        logic [7:0] b;
        b = 8'(base + (k + 1) * 17);
        return {8{b}};
    endfunction

    // Output and header monitors.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL m_axis_extra_beat got data=%h keep=%h last=%b, none expected",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {e.d, e.k, e.l}) begin
                        failures++;
                        $display("FAIL m_axis_beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.d, e.k, e.l);
                    end
                    if (check_lat) begin
                        checks++;
                        if (cyc - e.c !== 1) begin
                            failures++;
                            $display("FAIL m_axis_latency got %0d cycles expected 1", cyc - e.c);
                        end
                    end
                end
            end
            if (hdr_valid && hdr_ready) begin
                checks++;
                last_hdr_cyc = cyc;
                if (hq.size() == 0) begin
                    failures++;
                    $display("FAIL hdr_extra got slice=%h short=%b, none expected", header_slice, hdr_short);
                end else begin
                    hdr_t h;
                    h = hq.pop_front();
                    if ({header_slice, hdr_short} !== {h.s, h.sh}) begin
                        failures++;
                        $display("FAIL hdr_slice got slice=%h short=%b expected slice=%h short=%b",
                                 header_slice, hdr_short, h.s, h.sh);
                    end
                end
            end
            if (chk_ready && m_axis_tvalid && !m_axis_tready) begin
                checks++;
                if (s_axis_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL s_tready_follows_out got %b expected 0", s_axis_tready);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_hdr(input int n, input int base, input logic [7:0] keep0);
        hdr_t h;
        logic [DW-1:0] w;
        h.s = '0;
        for (int k = 0; k < n && k < HB; k++) begin
            w = bdata(base, k);
            if (k == 0) begin
                for (int i = 0; i < DW / 8; i++) begin
                    if (!keep0[i]) w[8*i +: 8] = 8'h00;
                end
            end
            h.s[SW-1-k*DW -: DW] = w;
        end
        h.sh = (n < HB);
        hq.push_back(h);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [7:0] k, input logic l);
        int  w;
        bit  done;
        w = 0;
        done = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                sb.push_back('{d, k, l, cyc});
                last_acc_cyc = cyc;
                done = 1;
            end else begin
                w++;
                if (w > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL send_beat_timeout got tready=0 for %0d cycles expected acceptance", w);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input int n, input int base, input logic [7:0] keep0);
        push_hdr(n, base, keep0);
        for (int k = 0; k < n; k++) begin
            send_beat(bdata(base, k), (k == 0) ? keep0 : 8'hFF, k == n - 1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb.size() != 0 || hq.size() != 0) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (sb.size() != 0 || hq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d beats %0d headers pending expected 0 0", name, sb.size(), hq.size());
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        hdr_ready     = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, header_slice, hdr_valid, hdr_short} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got mvalid=%b mdata=%h hvalid=%b hshort=%b slice=%h expected all 0",
                     m_axis_tvalid, m_axis_tdata, hdr_valid, hdr_short, header_slice);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready got %b expected 1", s_axis_tready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int b3;
        b3 = 0;
        check_lat = 1'b1;
        push_hdr(6, 0, 8'hFF);
        for (int k = 0; k < 6; k++) begin
            send_beat(bdata(0, k), 8'hFF, k == 5);
            if (k == 3) b3 = last_acc_cyc;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        drain("basic");
        check_lat = 1'b0;
        checks++;
        if (last_hdr_cyc !== b3 + 1) begin
            failures++;
            $display("FAIL basic_hdr_latency got cycle %0d expected %0d", last_hdr_cyc, b3 + 1);
        end
`ifdef HDR_SLICER_STATS_EN
        checks++;
        if (pkt_count !== 32'd1) begin
            failures++;
            $display("FAIL basic_pkt_count got %0d expected 1", pkt_count);
        end
`endif
    endtask

    task automatic test_short();
        send_packet(2, 8'h40, 8'hFF);
        drain("short");
`ifdef HDR_SLICER_STATS_EN
        checks++;
        if (short_count !== 16'd1 || pkt_count !== 32'd2) begin
            failures++;
            $display("FAIL short_counts got short=%0d pkt=%0d expected 1 2", short_count, pkt_count);
        end
`endif
    endtask

    task automatic test_keep();
        send_packet(4, 8'h80, 8'h0F);
        drain("keep");
    endtask

    task automatic test_back_to_back();
        bit stalled_ok;
        hdr_ready = 1'b0;
        send_packet(4, 8'h20, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hdr_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hdr_held got hdr_valid=%b expected 1", hdr_valid);
        end
        push_hdr(4, 8'h30, 8'hFF);
        s_axis_tdata  = bdata(8'h30, 0);
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        stalled_ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (s_axis_tready !== 1'b0 || hdr_valid !== 1'b1) stalled_ok = 0;
        end
        checks++;
        if (!stalled_ok) begin
            failures++;
            $display("FAIL b2b_stall got tready/hdr_valid not 0/1 during pending slice expected 0/1");
        end
        @(posedge clk);
        #1 hdr_ready = 1'b1;
        @(posedge clk);
        #1 hdr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat(bdata(8'h30, k), 8'hFF, k == 3);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hdr_valid !== 1'b1 || hq.size() != 1) begin
            failures++;
            $display("FAIL b2b_second_held got hdr_valid=%b pending=%0d expected 1 1", hdr_valid, hq.size());
        end
        hdr_ready = 1'b1;
        drain("b2b");
    endtask

    task automatic test_toggle();
        bit tog_done;
        tog_done  = 0;
        hdr_ready = 1'b1;
        chk_ready = 1'b1;
        fork
            begin
                send_packet(6, 8'h50, 8'hFF);
                tog_done = 1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1 m_axis_tready = !m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        chk_ready     = 1'b0;
        drain("toggle");
    endtask

    task automatic test_reset_mid();
        hdr_ready = 1'b1;
        send_beat(bdata(8'h70, 0), 8'hFF, 1'b0);
        send_beat(bdata(8'h70, 1), 8'hFF, 1'b0);
        s_axis_tdata = bdata(8'h70, 2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, header_slice, hdr_valid, hdr_short} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got mvalid=%b mdata=%h hvalid=%b hshort=%b slice=%h expected all 0",
                     m_axis_tvalid, m_axis_tdata, hdr_valid, hdr_short, header_slice);
        end
`ifdef HDR_SLICER_STATS_EN
        checks++;
        if (pkt_count !== 32'd0 || short_count !== 16'd0) begin
            failures++;
            $display("FAIL midreset_counts got pkt=%0d short=%0d expected 0 0", pkt_count, short_count);
        end
`endif
        sb.delete();
        hq.delete();
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_packet(5, 8'h90, 8'hFF);
        drain("midreset");
`ifdef HDR_SLICER_STATS_EN
        checks++;
        if (pkt_count !== 32'd1) begin
            failures++;
            $display("FAIL midreset_pkt_count got %0d expected 1", pkt_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_keep();
        test_back_to_back();
        test_toggle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
